// File: rtl/spi_master_tx_if.sv
// rtl/spi_master_tx_if.sv - word handshake and SPI wire bundle for spi_master_tx
interface spi_master_tx_if #(
  parameter int WIDTH = 16
);
  logic [WIDTH-1:0] tx_data;
  logic             tx_valid;
  logic             tx_ready;
  logic             mosi;
  logic             cs;
  logic             busy;
  logic             frame_done;

  modport master (
    output tx_data, tx_valid,
    input  tx_ready, mosi, cs, busy, frame_done
  );

  modport slave (
    input  tx_data, tx_valid,
    output tx_ready, mosi, cs, busy, frame_done
  );
endinterface

// File: rtl/spi_master_tx.sv
// rtl/spi_master_tx.sv - FIFO-fed LSB-first SPI transmit master, one cs frame per word
module spi_master_tx #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4,
  parameter int GAP   = 2
) (
  input  logic            sclk,
  input  logic            rst,
  spi_master_tx_if.slave  bus
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int BW = $clog2(WIDTH);
  localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;

  typedef enum logic [1:0] {IDLE, SHIFT, GAPW} state_t;

  state_t           state, state_n;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr, rptr;
  logic [AW:0]      count;
  logic [WIDTH-1:0] shreg, shreg_n;
  logic [BW-1:0]    bitcnt, bitcnt_n;
  logic [GW-1:0]    gcnt, gcnt_n;
  logic             cs_q, cs_q_n;
  logic             mosi_q, mosi_q_n;
  logic             fd_q, fd_q_n;
  logic             cs_r, mosi_r;
  logic             push, pop, start;
  logic             fifo_nonempty;

  assign fifo_nonempty  = (count != '0);
  assign bus.tx_ready   = (count != (AW+1)'(DEPTH));
  assign push           = bus.tx_valid && bus.tx_ready;
  assign bus.busy       = (state != IDLE) || fifo_nonempty;
  assign bus.frame_done = fd_q;
  assign bus.cs         = cs_r;
  assign bus.mosi       = mosi_r;

  always_comb begin
    state_n  = state;
    shreg_n  = shreg;
    bitcnt_n = bitcnt;
    gcnt_n   = gcnt;
    cs_q_n   = cs_q;
    mosi_q_n = mosi_q;
    fd_q_n   = 1'b0;
    start    = 1'b0;
    pop      = 1'b0;
    unique case (state)
      IDLE: begin
        if (fifo_nonempty) start = 1'b1;
      end
      SHIFT: begin
        if (bitcnt != BW'(WIDTH-1)) begin
          bitcnt_n = bitcnt + BW'(1);
          mosi_q_n = shreg[bitcnt + BW'(1)];
        end else begin
          cs_q_n   = 1'b1;
          mosi_q_n = 1'b0;
          fd_q_n   = 1'b1;
          gcnt_n   = '0;
          state_n  = GAPW;
        end
      end
      GAPW: begin
        if (gcnt == GW'(GAP-1)) begin
          if (fifo_nonempty) start = 1'b1;
          else               state_n = IDLE;
        end else begin
          gcnt_n = gcnt + GW'(1);
        end
      end
      default: state_n = IDLE;
    endcase
    // Head word goes straight into the shifter; bit 0 is already on mosi_q.
    if (start) begin
      pop      = 1'b1;
      shreg_n  = mem[rptr];
      mosi_q_n = mem[rptr][0];
      cs_q_n   = 1'b0;
      bitcnt_n = '0;
      state_n  = SHIFT;
    end
  end

  always_ff @(posedge sclk) begin
    if (push) mem[wptr] <= bus.tx_data;
  end

  always_ff @(posedge sclk) begin
    if (rst) begin
      state  <= IDLE;
      wptr   <= '0;
      rptr   <= '0;
      count  <= '0;
      shreg  <= '0;
      bitcnt <= '0;
      gcnt   <= '0;
      cs_q   <= 1'b1;
      mosi_q <= 1'b0;
      fd_q   <= 1'b0;
    end else begin
      state  <= state_n;
      shreg  <= shreg_n;
      bitcnt <= bitcnt_n;
      gcnt   <= gcnt_n;
      cs_q   <= cs_q_n;
      mosi_q <= mosi_q_n;
      fd_q   <= fd_q_n;
      if (push) wptr <= wptr + AW'(1);
      if (pop)  rptr <= rptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Retime to the falling edge so the slave sees a half period of setup.
  always_ff @(negedge sclk) begin
    cs_r   <= cs_q;
    mosi_r <= mosi_q;
  end
endmodule

// File: tb/tb_spi_master_tx.sv
// tb/tb_spi_master_tx.sv - scoreboard bench for spi_master_tx with a behavioural SPI slave
module tb_spi_master_tx;
  logic        sclk;
  logic        rst;
  logic        tv [2];
  logic [15:0] td [2];
  int          checks;
  int          errors;
  int          lowcnt  [2];
  int          frames  [2];
  int          pushed  [2];
  int          gap_exp [2];

  spi_master_tx_if #(.WIDTH(16)) ifa ();
  spi_master_tx_if #(.WIDTH(16)) ifb ();

  spi_master_tx #(.WIDTH(16), .DEPTH(4), .GAP(2)) u0 (.sclk(sclk), .rst(rst), .bus(ifa));
  spi_master_tx #(.WIDTH(16), .DEPTH(4), .GAP(1)) u1 (.sclk(sclk), .rst(rst), .bus(ifb));

  assign ifa.tx_valid = tv[0];
  assign ifa.tx_data  = td[0];
  assign ifb.tx_valid = tv[1];
  assign ifb.tx_data  = td[1];

  wire cs_s   [2];
  wire mosi_s [2];
  wire fd_s   [2];
  wire busy_s [2];
  wire rdy_s  [2];
  assign cs_s[0]   = ifa.cs;
  assign cs_s[1]   = ifb.cs;
  assign mosi_s[0] = ifa.mosi;
  assign mosi_s[1] = ifb.mosi;
  assign fd_s[0]   = ifa.frame_done;
  assign fd_s[1]   = ifb.frame_done;
  assign busy_s[0] = ifa.busy;
  assign busy_s[1] = ifb.busy;
  assign rdy_s[0]  = ifa.tx_ready;
  assign rdy_s[1]  = ifb.tx_ready;

  initial sclk = 1'b0;
  always #5 sclk = ~sclk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Per-instance scoreboard, slave model and monitor.
  for (genvar g = 0; g < 2; g++) begin : sb
    logic [15:0] exp_q [$];
    logic [15:0] sr = '0;
    int          nbits = 0;
    int          hi_run = 0;
    bit          have_prev = 1'b0;
    bit          prev_fd = 1'b0;

    always @(posedge sclk) begin
      if (rst) begin
        exp_q.delete();
        pushed[g] = frames[g];
      end else if (tv[g] === 1'b1 && rdy_s[g] === 1'b1) begin
        exp_q.push_back(td[g]);
        pushed[g]++;
      end
    end

    always @(posedge sclk) begin
      if (cs_s[g] === 1'b0) lowcnt[g]++;
      if (rst) begin
        nbits = 0;
        hi_run = 0;
        have_prev = 1'b0;
      end else begin
        if (busy_s[g] !== 1'b1) have_prev = 1'b0;
        if (cs_s[g] === 1'b0) begin
          if (nbits == 0) begin
            if (have_prev && gap_exp[g] != 0) chk("cs_high_gap", hi_run, gap_exp[g]);
            hi_run = 0;
            sr = '0;
          end
          if (nbits < 16) sr[nbits] = mosi_s[g];
          nbits++;
          if (nbits == 16) have_prev = 1'b1;
        end else begin
          nbits = 0;
          hi_run++;
        end
      end
    end

    always @(negedge sclk) begin
      if (!rst && fd_s[g] === 1'b1) begin
        chk("frame_done_pulse", prev_fd, 0);
        chk("frame_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) chk("slave_word", sr, exp_q.pop_front());
        chk("slave_bits", nbits, 16);
        frames[g]++;
      end
      prev_fd = (fd_s[g] === 1'b1);
    end
  end

  // Call at a negedge; returns at the negedge after the accepting posedge.
  task automatic send(input int s, input logic [15:0] w, output int stalls);
    int n;
    logic acc;
    n = 0;
    stalls = 0;
    tv[s] = 1'b1;
    td[s] = w;
    forever begin
      acc = rdy_s[s];
      @(negedge sclk);
      if (acc === 1'b1 || n >= 200) break;
      n++;
      stalls++;
    end
    tv[s] = 1'b0;
    chk("send_timeout", n < 200, 1);
  endtask

  task automatic wait_idle(input int s);
    int n;
    n = 0;
    while ((pushed[s] != frames[s] || busy_s[s] !== 1'b0) && n < 3000) begin
      @(negedge sclk);
      n++;
    end
    chk("idle_timeout", n < 3000, 1);
  endtask

  logic [15:0] b2b  [4] = '{16'h0001, 16'h8000, 16'hFFFF, 16'h1234};
  logic [15:0] full [6] = '{16'h1111, 16'h2222, 16'h3333, 16'h4444, 16'h5555, 16'h6666};

  initial begin
    int l0, f0, st, first;
    checks = 0;
    errors = 0;
    lowcnt = '{0, 0};
    frames = '{0, 0};
    pushed = '{0, 0};
    gap_exp = '{0, 0};
    tv = '{1'b0, 1'b0};
    td = '{16'h0, 16'h0};
    rst = 1'b1;
    repeat (3) @(negedge sclk);
    #1;
    for (int s = 0; s < 2; s++) begin
      chk("reset_cs", cs_s[s], 1);
      chk("reset_mosi", mosi_s[s], 0);
      chk("reset_ready", rdy_s[s], 1);
      chk("reset_busy", busy_s[s], 0);
      chk("reset_frame_done", fd_s[s], 0);
    end
    @(negedge sclk);
    rst = 1'b0;
    repeat (2) @(negedge sclk);

    // Single word
    l0 = lowcnt[0];
    f0 = frames[0];
    send(0, 16'hA5C3, st);
    wait_idle(0);
    chk("single_low_posedges", lowcnt[0] - l0, 16);
    chk("single_frames", frames[0] - f0, 1);
    chk("single_cs_after", cs_s[0], 1);

    // Back-to-back
    gap_exp[0] = 2;
    l0 = lowcnt[0];
    f0 = frames[0];
    for (int i = 0; i < 4; i++) begin
      chk("b2b_ready", rdy_s[0], 1);
      send(0, b2b[i], st);
    end
    wait_idle(0);
    chk("b2b_frames", frames[0] - f0, 4);
    chk("b2b_low_posedges", lowcnt[0] - l0, 64);

    // Full FIFO with held source
    l0 = lowcnt[0];
    f0 = frames[0];
    first = -1;
    for (int i = 0; i < 6; i++) begin
      send(0, full[i], st);
      if (st > 0 && first < 0) first = i;
    end
    wait_idle(0);
    chk("full_first_stall_word", first, 5);
    chk("full_frames", frames[0] - f0, 6);
    chk("full_low_posedges", lowcnt[0] - l0, 96);

    // Reset at P8 with two words queued
    gap_exp[0] = 0;
    repeat (3) @(negedge sclk);
    l0 = lowcnt[0];
    f0 = frames[0];
    send(0, 16'h00FF, st);
    send(0, 16'h1357, st);
    send(0, 16'h2468, st);
    repeat (6) @(negedge sclk);
    rst = 1'b1;
    @(negedge sclk);
    #1;
    chk("rst_mid_cs", cs_s[0], 1);
    chk("rst_mid_busy", busy_s[0], 0);
    chk("rst_mid_ready", rdy_s[0], 1);
    chk("rst_mid_low_posedges", lowcnt[0] - l0, 8);
    @(negedge sclk);
    rst = 1'b0;
    l0 = lowcnt[0];
    repeat (40) @(negedge sclk);
    chk("rst_no_resume_low", lowcnt[0] - l0, 0);
    chk("rst_no_frame_done", frames[0] - f0, 0);
    chk("rst_idle_cs", cs_s[0], 1);
    chk("rst_idle_busy", busy_s[0], 0);

    // Push landing on the last GAPW posedge
    gap_exp[0] = 3;
    f0 = frames[0];
    send(0, 16'hC0DE, st);
    repeat (18) @(negedge sclk);
    send(0, 16'h0BAD, st);
    wait_idle(0);
    chk("edge_frames", frames[0] - f0, 2);

    // GAP=1 instance
    gap_exp[1] = 1;
    l0 = lowcnt[1];
    f0 = frames[1];
    send(1, 16'hAAAA, st);
    send(1, 16'h5555, st);
    wait_idle(1);
    chk("gap1_frames", frames[1] - f0, 2);
    chk("gap1_low_posedges", lowcnt[1] - l0, 32);

    chk("all_sent_u0", frames[0] == pushed[0], 1);
    chk("all_sent_u1", frames[1] == pushed[1], 1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
endmodule

// File: doc/spi_master_tx.md
# spi_master_tx

SPI transmit master that feeds the 16-bit SPI slave receiver on the same `sclk`/`cs`/`mosi` wires. It accepts words through a valid/ready port into a 4-entry FIFO and serialises each word LSB-first as one chip-select frame. It guarantees the slave sees exactly 16 sampled bits per frame and at least `GAP` cs-high edges between frames. `frame_done` marks the single cycle in which the slave's `data` holds the complete word.

## Interface
- `WIDTH`, 16: bits per frame; the slave supports only 16.
- `DEPTH`, 4: FIFO entries, power of two.
- `GAP`, 2: minimum posedges of `sclk` with `cs` high between frames; must be ≥1.
- `sclk`  in  1  clock; rising-edge state, falling-edge output retime.
- `rst`  in  1  reset, synchronous, active-high; clock `sclk`.
- `tx_data`  in  WIDTH  word to send.
- `tx_valid`  in  1  `tx_data` is valid.
- `tx_ready`  out  1  FIFO not full; a push occurs when `tx_valid && tx_ready` at posedge.
- `mosi`  out  1  serial data to the slave; changes on negedge only.
- `cs`  out  1  chip select, active-low; changes on negedge only.
- `busy`  out  1  high when state≠IDLE or FIFO non-empty.
- `frame_done`  out  1  one-cycle pulse; slave `data` is complete while it is high.

## Operation
- Posedge registers:
  - FIFO: `wptr`, `rptr`, `count`.
  - `state` ∈ {IDLE, SHIFT, GAPW}.
  - `shreg[WIDTH-1:0]`, `bitcnt[3:0]`, `gcnt`.
  - `cs_q`, `mosi_q`, `frame_done`.
- Negedge registers: `cs <= cs_q`, `mosi <= mosi_q`. No other negedge logic.
- Reset values:
  - `state=IDLE`, `count=0`, pointers 0, `cs_q=1`, `mosi_q=0`, `frame_done=0`.
  - `cs=1` and `mosi=0` from the first negedge after the reset posedge.
  - `tx_ready=1`, `busy=0`.
- Frame start, in IDLE or at the last GAPW cycle when `count≠0`:
  - Pop FIFO head into `shreg`.
  - `cs_q<=0`, `mosi_q<=head[0]`, `bitcnt<=0`, `state<=SHIFT`.
- SHIFT:
  - If `bitcnt<15`: `bitcnt++` and `mosi_q<=shreg[bitcnt+1]`.
  - If `bitcnt==15`: `cs_q<=1`, `mosi_q<=0`, `frame_done<=1`, `gcnt<=0`, `state<=GAPW`.
- GAPW:
  - `frame_done<=0`.
  - If `gcnt==GAP-1`: start the next frame if `count≠0`, else go to IDLE.
  - Otherwise `gcnt++`.
- FIFO:
  - A push in the same posedge as a pop is legal; `count` is unchanged.
  - There is no bypass. A word pushed into an empty FIFO is popped at the next posedge at the earliest.
- Full FIFO: `tx_ready=0`; `tx_valid` is ignored and no data is overwritten.
- `frame_done` is registered and not combinational.
- Reset mid-frame:
  - The current word and all FIFO contents are discarded.
  - `cs` rises at the following negedge.
  - No partial frame resumes after reset.

## Timing
- Let P0 be the posedge that pops a word.
  - `cs` falls and `mosi=b0` at the negedge after P0.
  - The slave samples bit k at posedge P(k+1), k=0..15.
  - `cs_q` rises at P16, and `cs` rises at the negedge after P16.
  - `frame_done` is high from P16 to P17, exactly the window in which the slave's `data` equals the word. The slave clears `data` at P17.
- `mosi` and `cs` are stable for a half period before each sampling posedge.
- Push-to-pop latency is 1 cycle when idle. Push-to-slave-complete is 17 cycles.
- Back-to-back frames:
  - Period is 16+GAP cycles.
  - The slave sees exactly GAP posedges with `cs=1` (P17..P16+GAP).
  - The next pop happens at P16+GAP.
- `busy` falls in the cycle after the GAPW→IDLE transition when the FIFO is empty.

## Test plan
- **Single word.** After reset, push 0xA5C3 → exactly 16 posedges with `cs=0`; `mosi` bits LSB-first 1,1,0,0,0,0,1,1,1,0,1,0,0,1,0,1; slave `data`=0xA5C3 while `frame_done`=1; `cs=1` afterwards.
- **Back-to-back.** Push 0x0001, 0x8000, 0xFFFF, 0x1234 on consecutive cycles → `tx_ready` stays 1 (depth 4 consumed with one pop); 4 frames with period 18; 2 cs-high posedges between frames; slave words match in order.
- **Full.** Push 6 words with `tx_valid` held → `tx_ready` falls once `count=4`; the word presented while `tx_ready=0` is not lost (held by the source); all accepted words are sent in order and none are duplicated.
- **Reset mid-frame.** Assert `rst` at P8 of frame 0x00FF with 2 words queued → `cs=1` at the next negedge; `frame_done` is never asserted; FIFO is empty; `busy=0`; no further frames until a new push.
- **Empty/idle edge.** Push a word exactly at the GAPW last cycle → no start that cycle; the frame starts at the next posedge from IDLE; cs-high posedges seen by the slave = GAP+1.
- **GAP=1 variant.** Back-to-back 0xAAAA, 0x5555 → period 17; the slave sees one cs-high posedge and both words are correct.
